// File: rtl/cmd_issuer.sv
// cmd_issuer: buffers request bytes in a small FIFO and issues each one to the
// medium processing FSM as a start pulse followed by a data_valid beat. Every
// transaction is then classified as completed, errored or timed out, and
// saturating counters keep track of the outcomes.
module cmd_issuer #(
    parameter int DW      = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [DW-1:0]            req_data,
    output logic                     req_ready,
    input  logic                     fsm_ready,
    input  logic                     fsm_done,
    input  logic [DW-1:0]            fsm_data_out,
    output logic                     fsm_start,
    output logic                     fsm_data_valid,
    output logic [DW-1:0]            fsm_data_in,
    output logic                     busy,
    output logic                     result_valid,
    output logic [DW-1:0]            last_result,
    output logic                     err_pulse,
    output logic                     timeout_pulse,
    output logic [CNT_W-1:0]         ok_count,
    output logic [CNT_W-1:0]         err_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [LW-1:0]    FULL_LVL  = LW'(DEPTH);
    localparam logic [TW-1:0]    WAIT_LAST = TW'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DATA  = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + CNT_W'(1);
        end
        return result;
    endfunction

    logic [DW-1:0]    mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    state_t           state_r;
    logic [TW-1:0]    wait_cnt_r;
    logic             result_valid_r;
    logic             err_pulse_r;
    logic             timeout_pulse_r;
    logic [DW-1:0]    last_result_r;
    logic [CNT_W-1:0] ok_count_r;
    logic [CNT_W-1:0] err_count_r;

    logic             req_ready_s;
    logic             push_s;
    logic             pop_s;
    logic [DW-1:0]    data_in_s;

    // Full is judged on the registered level only, so a pop in the same cycle
    // never opens room for a push into a full FIFO.
    assign req_ready_s = (level_r != FULL_LVL);
    assign push_s      = req_valid && req_ready_s;
    assign pop_s       = (state_r == ST_DATA);

    // Drive the head byte only during the DATA beat; zero otherwise.
    always_comb begin
        data_in_s = {DW{1'b0}};
        if (state_r == ST_DATA) begin
            data_in_s = mem_r[rd_ptr_r];
        end else begin
            data_in_s = {DW{1'b0}};
        end
    end

    // FIFO storage: write the pushed byte at the write pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= req_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Issue FSM: sequencing, wait timer, outcome pulses, result capture, counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            wait_cnt_r      <= {TW{1'b0}};
            result_valid_r  <= 1'b0;
            err_pulse_r     <= 1'b0;
            timeout_pulse_r <= 1'b0;
            last_result_r   <= {DW{1'b0}};
            ok_count_r      <= {CNT_W{1'b0}};
            err_count_r     <= {CNT_W{1'b0}};
        end else begin
            result_valid_r  <= 1'b0;
            err_pulse_r     <= 1'b0;
            timeout_pulse_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if ((level_r != {LW{1'b0}}) && fsm_ready) begin
                        state_r <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_DATA;
                end
                ST_DATA: begin
                    state_r    <= ST_WAIT;
                    wait_cnt_r <= {TW{1'b0}};
                end
                ST_WAIT: begin
                    if (fsm_done) begin
                        last_result_r  <= fsm_data_out;
                        result_valid_r <= 1'b1;
                        ok_count_r     <= sat_inc(ok_count_r);
                        state_r        <= ST_IDLE;
                    end else if (fsm_ready) begin
                        // FSM went back to idle without reporting completion.
                        err_pulse_r <= 1'b1;
                        err_count_r <= sat_inc(err_count_r);
                        state_r     <= ST_IDLE;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        timeout_pulse_r <= 1'b1;
                        err_count_r     <= sat_inc(err_count_r);
                        state_r         <= ST_IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + TW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Hold req_ready low while reset is applied; afterwards it tracks !full.
    assign req_ready      = req_ready_s && !reset;
    assign fsm_start      = (state_r == ST_ISSUE);
    assign fsm_data_valid = (state_r == ST_DATA);
    assign fsm_data_in    = data_in_s;
    assign busy           = (state_r != ST_IDLE);
    assign result_valid   = result_valid_r;
    assign last_result    = last_result_r;
    assign err_pulse      = err_pulse_r;
    assign timeout_pulse  = timeout_pulse_r;
    assign ok_count       = ok_count_r;
    assign err_count      = err_count_r;
    assign fifo_level     = level_r;

endmodule

// File: tb/tb_cmd_issuer.sv
// Testbench for cmd_issuer: directed scenarios plus a randomized run checked
// against a queue-based transaction model.
module tb_cmd_issuer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [7:0] req_data;
    logic       req_ready;
    logic       fsm_ready;
    logic       fsm_done;
    logic [7:0] fsm_data_out;
    logic       fsm_start;
    logic       fsm_data_valid;
    logic [7:0] fsm_data_in;
    logic       busy;
    logic       result_valid;
    logic [7:0] last_result;
    logic       err_pulse;
    logic       timeout_pulse;
    logic [7:0] ok_count;
    logic [7:0] err_count;
    logic [2:0] fifo_level;

    int passed = 0;
    int total  = 0;

    cmd_issuer #(.DW(8), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fsm_ready(fsm_ready), .fsm_done(fsm_done), .fsm_data_out(fsm_data_out),
        .fsm_start(fsm_start), .fsm_data_valid(fsm_data_valid), .fsm_data_in(fsm_data_in),
        .busy(busy), .result_valid(result_valid), .last_result(last_result),
        .err_pulse(err_pulse), .timeout_pulse(timeout_pulse),
        .ok_count(ok_count), .err_count(err_count), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_data     = 8'h00;
        fsm_ready    = 1'b0;
        fsm_done     = 1'b0;
        fsm_data_out = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic push_byte(input logic [7:0] d, output bit accepted);
        req_valid = 1'b1;
        req_data  = d;
        accepted  = req_ready;
        tick();
        req_valid = 1'b0;
    endtask

    // Waits (bounded) for a start pulse, then steps to the DATA beat.
    task automatic wait_start(output bit seen, output bit start_after, output bit dv,
                              output logic [7:0] din, output logic [2:0] lvl_at_start);
        seen = 1'b0; start_after = 1'b0; dv = 1'b0; din = 8'h00; lvl_at_start = 3'd0;
        for (int i = 0; i < 40; i++) begin
            if (fsm_start) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (seen) begin
            lvl_at_start = fifo_level;
            fsm_ready    = 1'b0;
            tick();
            start_after = fsm_start;
            dv          = fsm_data_valid;
            din         = fsm_data_in;
        end
    endtask

    // From the DATA beat: mode 0 = done with rdata, 1 = ready without done,
    // 2 = stay silent until the timeout pulse. Ends on the first IDLE cycle.
    task automatic respond(input int mode, input logic [7:0] rdata, input int dly,
                           output int ncyc, output bit busy_held);
        ncyc = 0;
        busy_held = 1'b1;
        if (mode == 2) begin
            fsm_ready = 1'b0;
            while (!timeout_pulse && ncyc < 40) begin
                if (!busy) busy_held = 1'b0;
                tick();
                ncyc++;
            end
        end else begin
            tick();
            repeat (dly) tick();
            if (mode == 0) begin
                fsm_done     = 1'b1;
                fsm_data_out = rdata;
            end
            fsm_ready = 1'b1;
            tick();
            fsm_done = 1'b0;
        end
        fsm_ready = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (fifo_level !== 3'd0) $display("FAIL reset_level: got %0d want 0", fifo_level); else passed++;
        total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else passed++;
        total++;
        if ({fsm_start, fsm_data_valid, busy, result_valid, err_pulse, timeout_pulse} !== 6'b0 ||
            ok_count !== 8'd0 || err_count !== 8'd0 || last_result !== 8'd0 || fsm_data_in !== 8'd0)
            $display("FAIL reset_outputs: got st=%b dv=%b busy=%b ok=%0d err=%0d last=%h want all 0",
                     fsm_start, fsm_data_valid, busy, ok_count, err_count, last_result);
        else passed++;
    endtask

    task automatic test_complete();
        bit acc, seen, st2, dv, bh; logic [7:0] din; logic [2:0] lvl; int n;
        do_reset();
        fsm_ready = 1'b1;
        push_byte(8'h5A, acc);
        wait_start(seen, st2, dv, din, lvl);
        total++; if (seen !== 1'b1) $display("FAIL cmp_start: got %b want 1", seen); else passed++;
        total++; if (lvl !== 3'd1) $display("FAIL cmp_level_pre: got %0d want 1", lvl); else passed++;
        total++; if (st2 !== 1'b0) $display("FAIL cmp_start_width: got %b want 0", st2); else passed++;
        total++; if (dv !== 1'b1 || din !== 8'h5A) $display("FAIL cmp_data: got dv=%b data=%h want dv=1 data=5a", dv, din); else passed++;
        respond(0, 8'hAA, 1, n, bh);
        total++; if (fifo_level !== 3'd0) $display("FAIL cmp_level_post: got %0d want 0", fifo_level); else passed++;
        total++;
        if (result_valid !== 1'b1 || last_result !== 8'hAA || ok_count !== 8'd1 || err_count !== 8'd0 || busy !== 1'b0)
            $display("FAIL cmp_result: got rv=%b last=%h ok=%0d err=%0d busy=%b want 1 aa 1 0 0",
                     result_valid, last_result, ok_count, err_count, busy);
        else passed++;
        tick();
        total++; if (result_valid !== 1'b0) $display("FAIL cmp_rv_width: got %b want 0", result_valid); else passed++;
    endtask

    task automatic test_error();
        bit acc, seen, st2, dv, bh; logic [7:0] din; logic [2:0] lvl; int n;
        do_reset();
        fsm_ready = 1'b1;
        push_byte(8'h33, acc);
        wait_start(seen, st2, dv, din, lvl);
        respond(1, 8'h00, 1, n, bh);
        total++;
        if (err_pulse !== 1'b1 || result_valid !== 1'b0 || timeout_pulse !== 1'b0 ||
            err_count !== 8'd1 || ok_count !== 8'd0 || last_result !== 8'h00)
            $display("FAIL err_outcome: got ep=%b rv=%b tp=%b err=%0d ok=%0d last=%h want 1 0 0 1 0 00",
                     err_pulse, result_valid, timeout_pulse, err_count, ok_count, last_result);
        else passed++;
        tick();
        total++; if (err_pulse !== 1'b0) $display("FAIL err_pulse_width: got %b want 0", err_pulse); else passed++;
    endtask

    task automatic test_timeout();
        bit acc, seen, st2, dv, bh; logic [7:0] din; logic [2:0] lvl; int n;
        do_reset();
        fsm_ready = 1'b1;
        push_byte(8'h77, acc);
        wait_start(seen, st2, dv, din, lvl);
        respond(2, 8'h00, 0, n, bh);
        // WAIT is entered one cycle after the DATA beat; the pulse follows TIMEOUT cycles later.
        total++; if (n !== TIMEOUT + 1) $display("FAIL to_latency: got %0d want %0d", n, TIMEOUT + 1); else passed++;
        total++; if (bh !== 1'b1) $display("FAIL to_busy_held: got %b want 1", bh); else passed++;
        total++;
        if (timeout_pulse !== 1'b1 || err_pulse !== 1'b0 || err_count !== 8'd1 || ok_count !== 8'd0 || busy !== 1'b0)
            $display("FAIL to_outcome: got tp=%b ep=%b err=%0d ok=%0d busy=%b want 1 0 1 0 0",
                     timeout_pulse, err_pulse, err_count, ok_count, busy);
        else passed++;
    endtask

    task automatic test_back_to_back();
        bit acc [5]; bit seen, st2, dv, bh; logic [7:0] din; logic [2:0] lvl; int n;
        do_reset();
        fsm_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_byte(8'(i + 1), acc[i]);
            if (i == 3) begin
                total++; if (req_ready !== 1'b0) $display("FAIL b2b_full_ready: got %b want 0", req_ready); else passed++;
            end
        end
        total++;
        if ({acc[0], acc[1], acc[2], acc[3], acc[4]} !== 5'b11110)
            $display("FAIL b2b_accept: got %b%b%b%b%b want 11110", acc[0], acc[1], acc[2], acc[3], acc[4]);
        else passed++;
        total++; if (fifo_level !== 3'd4) $display("FAIL b2b_level: got %0d want 4", fifo_level); else passed++;
        fsm_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_start(seen, st2, dv, din, lvl);
            total++;
            if (seen !== 1'b1 || dv !== 1'b1 || din !== 8'(i + 1))
                $display("FAIL b2b_issue%0d: got seen=%b dv=%b data=%h want 1 1 %h", i, seen, dv, din, 8'(i + 1));
            else passed++;
            respond(0, 8'(8'hC0 + i), 0, n, bh);
        end
        total++; if (ok_count !== 8'd4) $display("FAIL b2b_ok: got %0d want 4", ok_count); else passed++;
        wait_start(seen, st2, dv, din, lvl);
        total++; if (seen !== 1'b0) $display("FAIL b2b_extra_issue: got %b want 0", seen); else passed++;
    endtask

    task automatic test_random();
        logic [7:0] q [$];
        logic [7:0] exp_last;
        int exp_ok, exp_err, mode, n, cnt, dly;
        bit acc, seen, st2, dv, bh; logic [7:0] din, rdata; logic [2:0] lvl;
        do_reset();
        exp_ok = 0; exp_err = 0; exp_last = 8'h00;
        for (int r = 0; r < 8; r++) begin
            fsm_ready = 1'b0;
            cnt = $urandom_range(1, 6);
            for (int k = 0; k < cnt; k++) begin
                rdata = 8'($urandom_range(0, 255));
                push_byte(rdata, acc);
                total++;
                if (acc !== (q.size() < DEPTH)) $display("FAIL rnd_accept: got %b want %b", acc, q.size() < DEPTH);
                else passed++;
                if (q.size() < DEPTH) q.push_back(rdata);
            end
            total++; if (fifo_level !== 3'(q.size())) $display("FAIL rnd_level: got %0d want %0d", fifo_level, q.size()); else passed++;
            fsm_ready = 1'b1;
            while (q.size() > 0) begin
                wait_start(seen, st2, dv, din, lvl);
                total++;
                if (seen !== 1'b1 || dv !== 1'b1 || din !== q[0])
                    $display("FAIL rnd_issue: got seen=%b dv=%b data=%h want 1 1 %h", seen, dv, din, q[0]);
                else passed++;
                void'(q.pop_front());
                mode  = $urandom_range(0, 5);
                mode  = (mode < 3) ? 0 : ((mode < 5) ? 1 : 2);
                rdata = 8'($urandom_range(0, 255));
                dly   = $urandom_range(0, 6);
                respond(mode, rdata, dly, n, bh);
                if (mode == 0) begin
                    exp_last = rdata;
                    if (exp_ok < 255) exp_ok++;
                end else begin
                    if (exp_err < 255) exp_err++;
                end
                if (mode == 2) begin
                    total++; if (n !== TIMEOUT + 1) $display("FAIL rnd_to_latency: got %0d want %0d", n, TIMEOUT + 1); else passed++;
                end
                total++;
                if (result_valid !== (mode == 0) || err_pulse !== (mode == 1) || timeout_pulse !== (mode == 2) ||
                    last_result !== exp_last || ok_count !== 8'(exp_ok) || err_count !== 8'(exp_err))
                    $display("FAIL rnd_outcome: mode=%0d got rv=%b ep=%b tp=%b last=%h ok=%0d err=%0d want last=%h ok=%0d err=%0d",
                             mode, result_valid, err_pulse, timeout_pulse, last_result, ok_count, err_count,
                             exp_last, exp_ok, exp_err);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid();
        bit acc, seen, st2, dv, any_act; logic [7:0] din; logic [2:0] lvl;
        do_reset();
        fsm_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(8'(8'h10 + i), acc);
        fsm_ready = 1'b1;
        wait_start(seen, st2, dv, din, lvl);
        tick();
        total++; if (fifo_level !== 3'd3 || busy !== 1'b1) $display("FAIL rst_pre: got level=%0d busy=%b want 3 1", fifo_level, busy); else passed++;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (fifo_level !== 3'd0 || fsm_start !== 1'b0 || fsm_data_valid !== 1'b0 || busy !== 1'b0 ||
            ok_count !== 8'd0 || err_count !== 8'd0)
            $display("FAIL rst_async: got level=%0d st=%b dv=%b busy=%b ok=%0d err=%0d want all 0",
                     fifo_level, fsm_start, fsm_data_valid, busy, ok_count, err_count);
        else passed++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        any_act = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fsm_start || result_valid || err_pulse || timeout_pulse || busy) any_act = 1'b1;
        end
        total++;
        if (any_act !== 1'b0 || ok_count !== 8'd0 || err_count !== 8'd0 || fifo_level !== 3'd0)
            $display("FAIL rst_after: got activity=%b ok=%0d err=%0d level=%0d want 0 0 0 0",
                     any_act, ok_count, err_count, fifo_level);
        else passed++;
    endtask

    task automatic test_saturation();
        bit acc, seen, st2, dv, bh; logic [7:0] din; logic [2:0] lvl; int n, exp_ok;
        do_reset();
        fsm_ready = 1'b1;
        exp_ok = 0;
        for (int i = 0; i < 256; i++) begin
            push_byte(8'(i), acc);
            wait_start(seen, st2, dv, din, lvl);
            respond(0, 8'(~i), 0, n, bh);
            if (exp_ok < 255) exp_ok++;
            if (i >= 253) begin
                total++;
                if (ok_count !== 8'(exp_ok) || result_valid !== 1'b1)
                    $display("FAIL sat_ok%0d: got ok=%0d rv=%b want %0d 1", i, ok_count, result_valid, exp_ok);
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_complete();
        test_error();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
